// File: rtl/axi_rs_arb_pkg.sv
// Shared types and helpers for the round-robin AXI stream arbiter.
package axi_rs_arb_pkg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_st_e;

   localparam int ARB_MAX_REQ = 16;

   // Width of a requester index; never narrower than one bit.
   function automatic int arb_id_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/axi_rs_rr_pick.sv
// Rotating-priority encoder: first set request at or above ptr, wrapping.
module axi_rs_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    ptr,
   output logic [ID_W-1:0]    win_id,
   output logic               any
);

   int              sum;
   logic [ID_W-1:0] idx;

   // Walk from the farthest offset back to ptr so the nearest request is written last.
   always_comb begin
      win_id = '0;
      any    = 1'b0;
      sum    = 0;
      idx    = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         sum = int'(ptr) + i;
         if (sum >= NUM_REQ) sum = sum - NUM_REQ;
         idx = ID_W'(sum);
         if (req[idx]) begin
            win_id = idx;
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi_rs_rr_arb.sv
// Round-robin burst-aware arbiter feeding a forward register stage.
// Optional beat counter enabled by AXI_RS_RR_ARB_PERF_EN.
module axi_rs_rr_arb
   import axi_rs_arb_pkg::*;
#(
   parameter int  NUM_REQ = 4,
   parameter int  PLD_W   = 64,
   localparam int ID_W    = arb_id_w(NUM_REQ)
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic [NUM_REQ-1:0]       req_valid_i,
   output logic [NUM_REQ-1:0]       req_ready_o,
   input  logic [NUM_REQ*PLD_W-1:0] req_payload_i,
   input  logic [NUM_REQ-1:0]       req_last_i,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic [PLD_W-1:0]         payload_o,
   output logic                     last_o,
   output logic [ID_W-1:0]          grant_id_o,
   output logic [31:0]              perf_beat_cnt_o
);

   arb_st_e         state_q, state_next;
   logic [ID_W-1:0] ptr_q, ptr_next;
   logic [ID_W-1:0] own_q, own_next;
   logic [ID_W-1:0] win_id, sel_id;
   logic            win_any, sel_vld, out_free, accept;
   logic            valid_q, last_q;
   logic [PLD_W-1:0] payload_q;
   logic [ID_W-1:0]  id_q;
   logic [PLD_W-1:0] pld_arr [NUM_REQ];

   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pld
         assign pld_arr[gi] = req_payload_i[gi*PLD_W +: PLD_W];
      end
   endgenerate

   function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
      return (int'(id) >= NUM_REQ - 1) ? '0 : id + 1'b1;
   endfunction

   axi_rs_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req    (req_valid_i),
      .ptr    (ptr_q),
      .win_id (win_id),
      .any    (win_any)
   );

   assign out_free = !valid_q || ready_i;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= ARB_IDLE;
         ptr_q   <= '0;
         own_q   <= '0;
      end else begin
         state_q <= state_next;
         ptr_q   <= ptr_next;
         own_q   <= own_next;
      end
   end

   always_comb begin
      state_next = state_q;
      ptr_next   = ptr_q;
      own_next   = own_q;
      if (accept) begin
         case (state_q)
            ARB_IDLE: begin
               if (req_last_i[sel_id]) begin
                  ptr_next = next_id(sel_id);
               end else begin
                  state_next = ARB_LOCKED;
                  own_next   = sel_id;
               end
            end
            ARB_LOCKED: begin
               if (req_last_i[own_q]) begin
                  state_next = ARB_IDLE;
                  ptr_next   = next_id(own_q);
               end
            end
         endcase
      end
   end

   // While a burst is open only the owner is looked at; others are masked off.
   always_comb begin
      sel_id      = win_id;
      sel_vld     = win_any;
      req_ready_o = '0;
      if (state_q == ARB_LOCKED) begin
         sel_id              = own_q;
         sel_vld             = req_valid_i[own_q];
         req_ready_o[own_q]  = out_free;
      end else if (win_any) begin
         req_ready_o[win_id] = out_free;
      end
      accept = sel_vld && out_free;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         valid_q   <= 1'b0;
         payload_q <= '0;
         last_q    <= 1'b0;
         id_q      <= '0;
      end else if (accept) begin
         valid_q   <= 1'b1;
         payload_q <= pld_arr[sel_id];
         last_q    <= req_last_i[sel_id];
         id_q      <= sel_id;
      end else if (ready_i) begin
         valid_q   <= 1'b0;
      end
   end

   assign valid_o    = valid_q;
   assign payload_o  = payload_q;
   assign last_o     = last_q;
   assign grant_id_o = id_q;

`ifdef AXI_RS_RR_ARB_PERF_EN
   logic [31:0] perf_q;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         perf_q <= '0;
      end else if (valid_q && ready_i && perf_q != 32'hFFFF_FFFF) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign perf_beat_cnt_o = perf_q;
`else
   assign perf_beat_cnt_o = '0;
`endif

endmodule
